// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode.
// Buffers up to DEPTH {instr, pc} pairs and presents the oldest one to decode
// with a valid/ready handshake (first-word-fall-through from storage). It
// pre-decodes beq/bne on the head entry, and a branch-redirect flush empties it.
module if_id_queue #(
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2,
  parameter logic [31:0] RESET_PC = 32'h0004_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic             out_is_beq,
  output logic             out_is_bne,
  input  logic             out_ready,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [5:0]     OP_BEQ   = 6'b000100;
  localparam logic [5:0]     OP_BNE   = 6'b000101;

  // Storage is data only: it is never reset, and only the pointers give it meaning.
  logic [63:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  logic [63:0]      w_head;

  assign w_valid  = (r_count != '0);
  assign in_ready = (r_count != FULL_CNT);
  assign w_push   = in_valid & in_ready & ~flush;
  assign w_pop    = w_valid & out_ready & ~flush;
  assign w_head   = r_mem[r_rd_ptr];

  assign count      = r_count;
  assign out_valid  = w_valid;
  assign out_instr  = w_valid ? w_head[63:32] : 32'h0;
  assign out_pc     = w_valid ? w_head[31:0]  : RESET_PC;
  assign out_is_beq = w_valid & (w_head[63:58] == OP_BEQ);
  assign out_is_bne = w_valid & (w_head[63:58] == OP_BNE);

  // Write the accepted fetch word into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_instr, in_pc};
    end
  end

  // Pointer and occupancy control. A flush overrides push and pop, and the
  // pointers wrap naturally because they are exactly log2(DEPTH) bits wide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reset, fill/drain, streaming across the
// pointer wrap, flush, beq/bne pre-decode and asynchronous reset mid-stream.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_is_beq;
  logic        out_is_bne;
  logic        out_ready;
  logic [2:0]  count;

  int n_total = 0;
  int n_bad   = 0;

  if_id_queue #(.DEPTH(4), .PTR_W(2), .RESET_PC(32'h0004_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_is_beq (out_is_beq),
    .out_is_bne (out_is_bne),
    .out_ready  (out_ready),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h2008_0005;
    in_pc     = 32'h0004_0000;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset held with fetch presenting a word
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_pc", out_pc, 32'h0004_0000);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_beq", 32'(out_is_beq), 32'd0);

    // First push after release
    rst = 1'b1;
    step();
    in_valid = 1'b0;
    chk("p1_valid", 32'(out_valid), 32'd1);
    chk("p1_instr", out_instr, 32'h2008_0005);
    chk("p1_pc", out_pc, 32'h0004_0000);
    chk("p1_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("p1_pop_count", 32'(count), 32'd0);

    // Fill to DEPTH with decode stalled
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_instr = 32'h2000_0000 | 32'(i);
      in_pc    = 32'h0004_0000 + 32'(4 * i);
      step();
    end
    in_valid = 1'b0;
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_ready", 32'(in_ready), 32'd0);
    // Fifth word offered while full is not taken
    in_valid = 1'b1;
    in_instr = 32'h2000_00FF;
    in_pc    = 32'h0004_0010;
    step();
    chk("full_count", 32'(count), 32'd4);
    chk("full_head", out_pc, 32'h0004_0000);

    // Drain in order; first drain cycle still offers the fifth word
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", out_pc, 32'h0004_0000 + 32'(4 * i));
      chk("drain_instr", out_instr, 32'h2000_0000 | 32'(i));
      step();
      in_valid = 1'b0;
      if (i == 0) chk("full_pop_no_push", 32'(count), 32'd3);
    end
    out_ready = 1'b0;
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_pc_idle", out_pc, 32'h0004_0000);

    // Stream at count=2 with simultaneous push and pop
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_instr = 32'h2000_0100 + 32'(i);
      in_pc    = 32'h0000_0100 + 32'(4 * i);
      step();
    end
    chk("stream_pre_count", 32'(count), 32'd2);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_instr = 32'h2000_0102 + 32'(k);
      in_pc    = 32'h0000_0108 + 32'(4 * k);
      chk("stream_pc", out_pc, 32'h0000_0100 + 32'(4 * k));
      chk("stream_instr", out_instr, 32'h2000_0100 + 32'(k));
      step();
      chk("stream_count", 32'(count), 32'd2);
    end
    chk("stream_head", out_pc, 32'h0000_0128);

    // Third entry, then flush with push and pop requested together
    out_ready = 1'b0;
    in_instr  = 32'h2000_0130;
    in_pc     = 32'h0000_0130;
    step();
    chk("flush_pre_count", 32'(count), 32'd3);
    flush     = 1'b1;
    in_instr  = 32'h2000_DEAD;
    in_pc     = 32'h000D_EAD0;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_pc", out_pc, 32'h0004_0000);
    step();
    chk("flush_dropped", 32'(out_valid), 32'd0);

    // Branch pre-decode
    in_valid = 1'b1;
    in_instr = 32'h1109_0003;
    in_pc    = 32'h0004_0100;
    step();
    chk("beq_flag", 32'(out_is_beq), 32'd1);
    chk("beq_not_bne", 32'(out_is_bne), 32'd0);
    in_instr = 32'h1509_0002;
    in_pc    = 32'h0004_0104;
    step();
    in_valid = 1'b0;
    chk("hold_beq", 32'(out_is_beq), 32'd1);
    chk("hold_instr", out_instr, 32'h1109_0003);
    out_ready = 1'b1;
    step();
    chk("bne_flag", 32'(out_is_bne), 32'd1);
    chk("bne_not_beq", 32'(out_is_beq), 32'd0);
    chk("bne_pc", out_pc, 32'h0004_0104);
    step();
    out_ready = 1'b0;
    chk("empty_beq", 32'(out_is_beq), 32'd0);
    chk("empty_bne", 32'(out_is_bne), 32'd0);

    // Asynchronous reset between edges at count=3
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = 32'h2000_0200 + 32'(i);
      in_pc    = 32'h0004_0200 + 32'(4 * i);
      step();
    end
    in_valid = 1'b0;
    chk("async_pre_count", 32'(count), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_ready", 32'(in_ready), 32'd1);
    chk("async_pc", out_pc, 32'h0004_0000);
    step();
    rst = 1'b1;
    step();
    chk("async_post_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction queue between instruction fetch and decode in the MIPS pipeline.
- Accepts fetched instruction/PC pairs from fetch and buffers up to DEPTH entries. Presents the oldest entry to decode with a valid/ready handshake.
- Pre-decodes branch opcodes. Discards all buffered entries on a branch-redirect flush so decode never sees wrong-path instructions.

Parameters:
- DEPTH, 4, number of entries; must be a power of two, at least 2.
- PTR_W, 2, pointer width, equal to log2(DEPTH).
- RESET_PC, 32'h0004_0000, value driven on out_pc while empty; matches the text-segment base used by fetch.

Ports:
- clk  input  1  pipeline clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  fetch presents a valid instruction.
- in_instr  input  32  fetched instruction word.
- in_pc  input  32  byte address of in_instr.
- in_ready  output  1  queue can accept an entry this cycle.
- flush  input  1  branch taken / redirect; empties the queue.
- out_valid  output  1  out_instr/out_pc hold a valid entry.
- out_instr  output  32  oldest buffered instruction.
- out_pc  output  32  PC of out_instr.
- out_is_beq  output  1  out_instr[31:26] == 6'b000100, gated by out_valid.
- out_is_bne  output  1  out_instr[31:26] == 6'b000101, gated by out_valid.
- out_ready  input  1  decode consumes the head entry this cycle.
- count  output  PTR_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 64-bit array (instr, pc), write pointer wr_ptr, read pointer rd_ptr, and occupancy count.
- Reset (rst=0, asynchronous): wr_ptr=rd_ptr=0, count=0. The storage array is not reset.
  - Outputs during reset: out_valid=0, out_instr=0, out_pc=RESET_PC, out_is_beq=out_is_bne=0, in_ready=1.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Push: fires when in_valid && in_ready && !flush. Writes {in_instr,in_pc} at wr_ptr, then wr_ptr+1 (wraps at DEPTH).
- Pop: fires when out_valid && out_ready && !flush. Advances rd_ptr by 1 (wraps at DEPTH).
- count: next = count + push - pop. Simultaneous push and pop leaves count unchanged.
- Flags:
  - in_ready = (count != DEPTH), combinational from registered count.
  - When full, no push is accepted even if a pop occurs in the same cycle; no bypass path.
- Output, first-word-fall-through from storage:
  - out_valid = (count != 0).
  - out_instr/out_pc = entry at rd_ptr when valid, else 0 / RESET_PC.
  - Latency: an entry pushed at edge N is visible on out_* after edge N, so it is poppable at edge N+1.
  - No combinational path from in_* to out_*: an empty queue does not pass data through.
- Flush (priority over everything except reset): at the clock edge, rd_ptr=wr_ptr=0 and count=0.
  - The in_* word presented in the same cycle is dropped.
  - A pop requested in the same cycle does not count; decode must ignore the head entry.
- Holding: out_* stay stable while out_valid=1 and out_ready=0.
- Fetch holds in_instr/in_pc stable while in_valid=1 and in_ready=0. The queue relies on this but does not check it.
- State summary: EMPTY (count=0), PARTIAL, FULL (count=DEPTH).
  - Transitions follow push/pop; flush from any state goes to EMPTY.
  - No underflow or overflow is possible, because push and pop are gated by in_ready and out_valid.

Test Plan:
- Reset: hold rst=0 with in_valid=1 -> out_valid=0, count=0, out_pc=32'h00040000, in_ready=1. After release, one push of instr 32'h20080005 at pc 32'h00040000 -> next cycle out_valid=1 with exactly that pair.
- Fill with out_ready=0: push pcs 0x40000, 0x40004, 0x40008, 0x4000C -> count=4, in_ready=0. A fifth push with pc 0x40010 is ignored. Then drain with out_ready=1 -> pcs emerge in order, count ends at 0.
- Simultaneous push/pop at count=2 for 10 cycles -> count stays 2, order preserved across pointer wrap (rd_ptr passes 3->0).
- Flush at count=3 with in_valid=1 and out_ready=1 in the same cycle -> next cycle count=0, out_valid=0. The incoming word never appears at the output.
- Pre-decode: push 32'h11090003 (beq) then 32'h15090002 (bne) -> out_is_beq=1 then out_is_bne=1. When empty, both flags are 0.
- Async reset mid-stream: drop rst between clock edges at count=3 -> out_valid=0 and count=0 before the next edge.
